// File: rtl/jb_spi_master_dsa.sv
// SPI-style DSA programming master: shifts a parallel word out on sclk/mosi, csn doubles as LE.
// Optional JB_SPI_DSA_SKIP_DUP_EN suppresses frames that repeat the last word transmitted.
module jb_spi_master_dsa #(
  parameter int TRN_WIDTH = 8,
  parameter int MSB_FIRST = 0,
  parameter int CLK_DIV   = 4,
  parameter int CSN_SETUP = 2,
  parameter int LE_SETUP  = 2,
  parameter int CSN_GAP   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [TRN_WIDTH-1:0] trn_txd,
  input  logic                 trn_valid,
  output logic                 trn_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 sclk,
  output logic                 csn,
  output logic                 mosi
);

  localparam int M1 = (CLK_DIV > CSN_SETUP) ? CLK_DIV : CSN_SETUP;
  localparam int M2 = (LE_SETUP > CSN_GAP) ? LE_SETUP : CSN_GAP;
  localparam int PH_MAX = (M1 > M2) ? M1 : M2;
  localparam int PH_W = $clog2(PH_MAX) + 1;
  localparam int BIT_W = $clog2(TRN_WIDTH) + 1;

  localparam logic [PH_W-1:0] DIV_L = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] SET_L = PH_W'(CSN_SETUP - 1);
  localparam logic [PH_W-1:0] LE_L  = PH_W'(LE_SETUP - 1);
  localparam logic [PH_W-1:0] GAP_L = PH_W'(CSN_GAP - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(TRN_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_e;

  state_e               state_q;
  logic [PH_W-1:0]      ph_q;
  logic [BIT_W-1:0]     bit_q;
  logic [TRN_WIDTH-1:0] sh_q;
  logic [TRN_WIDTH-1:0] sh_d;
  logic                 first_d;
  logic                 next_d;
  logic                 skip_d;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 sclk_q;
  logic                 csn_q;
  logic                 mosi_q;

  always_comb begin
    sh_d    = '0;
    first_d = 1'b0;
    next_d  = 1'b0;
    if (MSB_FIRST != 0) begin
      sh_d    = sh_q << 1;
      first_d = trn_txd[TRN_WIDTH-1];
      next_d  = sh_q[TRN_WIDTH-2];
    end else begin
      sh_d    = sh_q >> 1;
      first_d = trn_txd[0];
      next_d  = sh_q[1];
    end
  end

`ifdef JB_SPI_DSA_SKIP_DUP_EN
  logic [TRN_WIDTH-1:0] word_q;
  logic [TRN_WIDTH-1:0] last_q;
  logic                 have_q;

  assign skip_d = have_q && (trn_txd == last_q);
`else
  assign skip_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    done_q <= 1'b0;
    if (rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      csn_q   <= 1'b1;
      mosi_q  <= 1'b0;
`ifdef JB_SPI_DSA_SKIP_DUP_EN
      have_q  <= 1'b0;
      word_q  <= '0;
      last_q  <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (trn_valid && ready_q) begin
            ready_q <= 1'b0;
            if (skip_d) begin
              // repeat of the latched word: report completion without touching the bus
              done_q <= 1'b1;
            end else begin
              state_q <= SETUP;
              busy_q  <= 1'b1;
              ph_q    <= SET_L;
              bit_q   <= '0;
              sh_q    <= trn_txd;
              csn_q   <= 1'b0;
              sclk_q  <= 1'b0;
              mosi_q  <= first_d;
`ifdef JB_SPI_DSA_SKIP_DUP_EN
              word_q  <= trn_txd;
`endif
            end
          end
        end
        SETUP: begin
          if (ph_q == '0) begin
            state_q <= HIGH;
            ph_q    <= DIV_L;
            sclk_q  <= 1'b1;
          end else begin
            ph_q <= ph_q - 1'b1;
          end
        end
        HIGH: begin
          if (ph_q == '0) begin
            sclk_q <= 1'b0;
            if (bit_q == LAST_BIT) begin
              state_q <= HOLD;
              ph_q    <= LE_L;
            end else begin
              state_q <= LOW;
              ph_q    <= DIV_L;
              bit_q   <= bit_q + 1'b1;
              sh_q    <= sh_d;
              mosi_q  <= next_d;
            end
          end else begin
            ph_q <= ph_q - 1'b1;
          end
        end
        LOW: begin
          if (ph_q == '0) begin
            state_q <= HIGH;
            ph_q    <= DIV_L;
            sclk_q  <= 1'b1;
          end else begin
            ph_q <= ph_q - 1'b1;
          end
        end
        HOLD: begin
          if (ph_q == '0) begin
            state_q <= GAP;
            ph_q    <= GAP_L;
            csn_q   <= 1'b1;
            mosi_q  <= 1'b0;
            done_q  <= (CSN_GAP == 1);
          end else begin
            ph_q <= ph_q - 1'b1;
          end
        end
        GAP: begin
          if (ph_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef JB_SPI_DSA_SKIP_DUP_EN
            last_q  <= word_q;
            have_q  <= 1'b1;
`endif
          end else begin
            ph_q   <= ph_q - 1'b1;
            done_q <= (ph_q == PH_W'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign trn_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign csn       = csn_q;
  assign mosi      = mosi_q;

endmodule
